// File: rtl/stream_burst_writer.sv
// Stream-to-DDR write-burst feeder. Buffers a valid/ready word stream in a
// first-word-fall-through FIFO and issues fixed-length write bursts to
// sequential, wrapping addresses. A flush pulse drains a partial remainder.
module stream_burst_writer #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 24,
  parameter int                    BURST_LEN  = 64,
  parameter int                    FIFO_AW    = 9,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_WIDTH:0]   ADDR_SPAN  = 'h100000
) (
  input  logic                  phy_clk,
  input  logic                  rst_n,
  input  logic                  calib_done,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  wr_burst_req,
  output logic [9:0]            wr_burst_len,
  output logic [ADDR_WIDTH-1:0] wr_burst_addr,
  input  logic                  wr_burst_data_req,
  output logic [DATA_WIDTH-1:0] wr_burst_data,
  input  logic                  wr_burst_finish,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  busy,
  output logic                  err_overreq
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam int                    DEPTH      = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]      DEPTH_LVL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]      BURST_LVL  = (FIFO_AW + 1)'(BURST_LEN);
  localparam logic [FIFO_AW:0]      LVL_ONE    = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0]    PTR_ONE    = FIFO_AW'(1);
  localparam logic [9:0]            BURST_LEN10 = 10'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]   BURST_ADR  = (ADDR_WIDTH + 1)'(BURST_LEN);
  // One past the last legal word of the window; widened so BASE+SPAN cannot overflow.
  localparam logic [ADDR_WIDTH:0]   ADDR_LIMIT = {1'b0, BASE_ADDR} + ADDR_SPAN;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  state_t                state;
  logic [9:0]            words_sent;
  logic                  flush_pending;
  logic                  push;
  logic                  pop;
  logic                  overreq;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign in_ready = (fifo_level < DEPTH_LVL);
  assign push     = in_valid && in_ready;
  assign pop      = wr_burst_data_req && (state == S_BURST) && (words_sent < wr_burst_len);
  assign overreq  = wr_burst_data_req && (state == S_BURST) && (words_sent == wr_burst_len);
  assign busy     = (state != S_IDLE);
  // Head word is presented combinationally; an empty FIFO shows zero.
  assign wr_burst_data = (fifo_level == '0) ? '0 : mem[rd_ptr];

  // FIFO storage write.
  // NOTE: the storage array has no reset; emptiness is tracked by fifo_level,
  // so stale contents are never observed and the array can map to RAM.
  always_ff @(posedge phy_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the level.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge phy_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_ONE;
        2'b01:   fifo_level <= fifo_level - LVL_ONE;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Address of the burst after the current one, wrapping when the next full
  // burst would not fit in the window.
  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    addr_sum  = {1'b0, wr_burst_addr} + (ADDR_WIDTH + 1)'(wr_burst_len);
    next_addr = addr_sum[ADDR_WIDTH-1:0];
    if ((addr_sum + BURST_ADR) > ADDR_LIMIT) next_addr = BASE_ADDR;
  end

  // Burst sequencer: launch decisions in IDLE, word accounting in BURST.
  always_ff @(posedge phy_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wr_burst_req  <= 1'b0;
      wr_burst_len  <= '0;
      wr_burst_addr <= BASE_ADDR;
      words_sent    <= '0;
      flush_pending <= 1'b0;
      err_overreq   <= 1'b0;
    end else begin
      if (overreq) err_overreq <= 1'b1;
      case (state)
        S_IDLE: begin
          if (calib_done && (fifo_level >= BURST_LVL)) begin
            wr_burst_len <= BURST_LEN10;
            words_sent   <= '0;
            wr_burst_req <= 1'b1;
            state        <= S_BURST;
          end else if (calib_done && flush_pending && (fifo_level != '0)) begin
            wr_burst_len  <= 10'(fifo_level);
            words_sent    <= '0;
            wr_burst_req  <= 1'b1;
            flush_pending <= 1'b0;
            state         <= S_BURST;
          end else if (flush_pending && (fifo_level == '0)) begin
            flush_pending <= 1'b0;
          end
        end
        S_BURST: begin
          if (pop) words_sent <= words_sent + 10'd1;
          if (wr_burst_finish) begin
            wr_burst_req  <= 1'b0;
            wr_burst_addr <= next_addr;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A new flush request wins over a same-cycle clear.
      if (flush) flush_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_burst_writer.sv
// Directed bench for stream_burst_writer with a 256-word address window.
module tb_stream_burst_writer;

  logic        phy_clk;
  logic        rst_n;
  logic        calib_done;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        flush;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [23:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic [63:0] wr_burst_data;
  logic        wr_burst_finish;
  logic [9:0]  fifo_level;
  logic        busy;
  logic        err_overreq;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_q[$];

  stream_burst_writer #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(24),
    .BURST_LEN (64),
    .FIFO_AW   (9),
    .BASE_ADDR (24'd0),
    .ADDR_SPAN (25'd256)
  ) dut (
    .phy_clk          (phy_clk),
    .rst_n            (rst_n),
    .calib_done       (calib_done),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .flush            (flush),
    .wr_burst_req     (wr_burst_req),
    .wr_burst_len     (wr_burst_len),
    .wr_burst_addr    (wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_data    (wr_burst_data),
    .wr_burst_finish  (wr_burst_finish),
    .fifo_level       (fifo_level),
    .busy             (busy),
    .err_overreq      (err_overreq)
  );

  initial phy_clk = 1'b0;
  always #5 phy_clk = ~phy_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_req"}, wr_burst_req, 0);
    check({tag, "_len"}, wr_burst_len, 0);
    check({tag, "_addr"}, wr_burst_addr, 0);
    check({tag, "_data"}, wr_burst_data, 0);
    check({tag, "_level"}, fifo_level, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err_overreq, 0);
    check({tag, "_flush_pending"}, dut.flush_pending, 0);
  endtask

  // Pushes n words base+i with calib_done held by the caller; the model
  // decides whether each word should be accepted.
  task automatic push_words(input int n, input logic [63:0] base);
    logic exp_rdy;
    for (int i = 0; i < n; i++) begin
      exp_rdy = (model_q.size() < 512);
      check("in_ready", in_ready, exp_rdy);
      in_valid = 1'b1;
      in_data  = base + 64'(i);
      @(negedge phy_clk);
      if (exp_rdy) model_q.push_back(base + 64'(i));
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int waited = 0;
    while (wr_burst_req !== 1'b1 && waited < 2000) begin
      @(negedge phy_clk);
      waited++;
    end
    check({tag, "_req_seen"}, wr_burst_req, 1);
  endtask

  // Controller model: waits for a request, checks it, issues len+extra data
  // requests, then pulses finish.
  task automatic do_burst(input logic [23:0] exp_addr, input int exp_len, input int extra);
    logic [63:0] exp_word;
    wait_req("burst");
    if (wr_burst_req !== 1'b1) return;
    check("burst_addr", wr_burst_addr, exp_addr);
    check("burst_len", wr_burst_len, exp_len);
    check("burst_busy", busy, 1);
    for (int i = 0; i < exp_len + extra; i++) begin
      wr_burst_data_req = 1'b1;
      if (i < exp_len) begin
        exp_word = (model_q.size() != 0) ? model_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check("burst_data", wr_burst_data, exp_word);
      end
      @(negedge phy_clk);
    end
    wr_burst_data_req = 1'b0;
    wr_burst_finish   = 1'b1;
    @(negedge phy_clk);
    wr_burst_finish = 1'b0;
    check("burst_req_drop", wr_burst_req, 0);
  endtask

  logic [23:0] t4_addr [8];
  logic [63:0] exp_word6;

  initial begin
    t4_addr = '{24'd100, 24'd164, 24'd0, 24'd64, 24'd128, 24'd192, 24'd0, 24'd64};
    rst_n = 1'b0; calib_done = 1'b0; in_valid = 1'b0; in_data = '0;
    flush = 1'b0; wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
    repeat (2) @(negedge phy_clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge phy_clk);

    // Hold-off until calibration, then one full burst of words 0..63.
    push_words(64, 64'd0);
    check("t1_no_req", wr_burst_req, 0);
    check("t1_level", fifo_level, 64);
    calib_done = 1'b1;
    #1;
    check("t1_req_not_yet", wr_burst_req, 0);
    @(negedge phy_clk);
    check("t1_req_rise", wr_burst_req, 1);
    do_burst(24'd0, 64, 0);
    check("t1_next_addr", wr_burst_addr, 64);
    check("t1_level_empty", fifo_level, 0);
    check("t1_idle", busy, 0);

    // A finish pulse in IDLE must not move the address.
    wr_burst_finish = 1'b1;
    @(negedge phy_clk);
    wr_burst_finish = 1'b0;
    @(negedge phy_clk);
    check("idle_finish_addr", wr_burst_addr, 64);
    check("idle_finish_req", wr_burst_req, 0);

    // Continuous stream, back-to-back bursts, wrapping at 256.
    rst_n = 1'b0;
    @(negedge phy_clk);
    rst_n = 1'b1;
    @(negedge phy_clk);
    model_q.delete();
    calib_done = 1'b1;
    fork
      begin : producer
        int   k;
        int   guard;
        logic rdy;
        k = 0;
        guard = 0;
        while (k < 1024 && guard < 20000) begin
          in_valid = 1'b1;
          in_data  = 64'hA500_0000_0000_0000 | 64'(k);
          rdy      = in_ready;
          @(posedge phy_clk);
          if (rdy) begin
            model_q.push_back(in_data);
            k++;
          end
          @(negedge phy_clk);
          guard++;
        end
        in_valid = 1'b0;
        check("t2_all_pushed", k, 1024);
      end
      begin : consumer
        for (int b = 0; b < 16; b++) do_burst(24'((b % 4) * 64), 64, 0);
      end
    join
    check("t2_level", fifo_level, 0);
    check("t2_addr", wr_burst_addr, 0);
    check("t2_model_empty", model_q.size(), 0);

    // Flush: 100 words give a full burst then a 36-word remainder.
    calib_done = 1'b0;
    push_words(100, 64'hB000);
    flush = 1'b1;
    @(negedge phy_clk);
    flush = 1'b0;
    check("t3_pending", dut.flush_pending, 1);
    check("t3_level", fifo_level, 100);
    check("t3_no_req", wr_burst_req, 0);
    calib_done = 1'b1;
    @(negedge phy_clk);
    check("t3_req_rise", wr_burst_req, 1);
    do_burst(24'd0, 64, 0);
    do_burst(24'd64, 36, 0);
    check("t3_pending_clear", dut.flush_pending, 0);
    check("t3_level_empty", fifo_level, 0);
    check("t3_addr", wr_burst_addr, 100);

    // Fill to 512; the 513th word is refused. Then drain across the wrap.
    calib_done = 1'b0;
    push_words(513, 64'hC000);
    check("t4_level_full", fifo_level, 512);
    check("t4_not_ready", in_ready, 0);
    calib_done = 1'b1;
    for (int b = 0; b < 8; b++) do_burst(t4_addr[b], 64, 0);
    check("t4_level_empty", fifo_level, 0);
    check("t4_ready", in_ready, 1);
    check("t4_addr", wr_burst_addr, 128);

    // Over-request: 65 data requests for a 64-word burst.
    calib_done = 1'b0;
    push_words(70, 64'hD000);
    check("t5_err_before", err_overreq, 0);
    calib_done = 1'b1;
    @(negedge phy_clk);
    do_burst(24'd128, 64, 1);
    check("t5_err", err_overreq, 1);
    check("t5_level", fifo_level, 6);
    @(negedge phy_clk);
    check("t5_err_sticky", err_overreq, 1);
    check("t5_addr", wr_burst_addr, 192);

    // Reset asserted mid-burst after 10 pops.
    calib_done = 1'b0;
    push_words(64, 64'hE000);
    check("t6_level", fifo_level, 70);
    calib_done = 1'b1;
    wait_req("t6");
    check("t6_addr", wr_burst_addr, 192);
    for (int i = 0; i < 10; i++) begin
      wr_burst_data_req = 1'b1;
      exp_word6 = (model_q.size() != 0) ? model_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      check("t6_data", wr_burst_data, exp_word6);
      @(negedge phy_clk);
    end
    check("t6_level_after_pops", fifo_level, 60);
    wr_burst_data_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("t6_async");
    @(negedge phy_clk);
    rst_n = 1'b1;
    model_q.delete();
    @(negedge phy_clk);
    check("t6_post_level", fifo_level, 0);
    check("t6_post_addr", wr_burst_addr, 0);
    check("t6_post_req", wr_burst_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_burst_writer.md
Name: stream_burst_writer

Overview:
- Upstream feeder for the DDR3 memory controller write-burst port.
- Accepts a valid/ready stream of DATA_WIDTH words and buffers them in an internal first-word-fall-through FIFO.
- Issues fixed-length write bursts to sequentially incrementing, wrapping DDR addresses.
- A flush pulse drains any partial remainder as a short burst. Replaces the test-pattern generator when real data (camera/ADC stream) is written to DDR.

Parameters:
DATA_WIDTH, 64, stream and burst data width.
ADDR_WIDTH, 24, burst address width; address unit is one DATA_WIDTH word.
BURST_LEN, 64, full burst length in words; legal range 1..2**FIFO_AW, and at most 1023.
FIFO_AW, 9, FIFO address bits; depth = 2**FIFO_AW (512).
BASE_ADDR, 0, first burst address and wrap target.
ADDR_SPAN, 24'h100000, size of the address window in words.

Ports:
phy_clk  in  1  controller clock; all logic runs in this domain.
rst_n  in  1  asynchronous active-low reset.
calib_done  in  1  DDR calibration complete; no burst launches while low.
in_valid  in  1  stream word valid.
in_data  in  DATA_WIDTH  stream word.
in_ready  out  1  FIFO can accept a word.
flush  in  1  one-cycle pulse: write out the partial remainder.
wr_burst_req  out  1  write burst request.
wr_burst_len  out  10  words in the current burst.
wr_burst_addr  out  ADDR_WIDTH  start address of the current burst.
wr_burst_data_req  in  1  controller consumes one word this cycle.
wr_burst_data  out  DATA_WIDTH  FIFO head word.
wr_burst_finish  in  1  one-cycle pulse: burst complete.
fifo_level  out  FIFO_AW+1  current FIFO occupancy.
busy  out  1  high when state is not IDLE.
err_overreq  out  1  sticky; controller requested more words than wr_burst_len.

Behaviour:
- Reset values:
  - in_ready=1, wr_burst_req=0, wr_burst_len=0, wr_burst_addr=BASE_ADDR, wr_burst_data=0 (FIFO empty).
  - fifo_level=0, busy=0, err_overreq=0, flush_pending=0, state=IDLE.
  - Reset asserted mid-burst aborts immediately; FIFO contents are discarded.
- FIFO push and pop:
  - Push when in_valid && in_ready. in_ready = (fifo_level < 2**FIFO_AW), combinational from the level.
  - Pop when wr_burst_data_req && state==BURST && words_sent < wr_burst_len.
  - wr_burst_data is always the FIFO head (FWFT). It is valid in the same cycle as wr_burst_data_req and advances on the next edge.
  - Simultaneous push and pop leaves fifo_level unchanged. Pushing into an empty FIFO makes the head visible the next cycle.
- flush_pending is set by the flush pulse.
- State IDLE:
  - If calib_done and fifo_level >= BURST_LEN: latch len=BURST_LEN and go to BURST.
  - Else if calib_done, flush_pending and 0 < fifo_level < BURST_LEN: latch len=fifo_level, clear flush_pending, go to BURST.
  - Else if flush_pending and fifo_level==0: clear flush_pending.
  - wr_burst_req rises on the cycle after the launch condition is true.
  - Full bursts take priority over flush, so flush_pending survives until the remainder is below BURST_LEN.
- State BURST:
  - wr_burst_req=1; wr_burst_len and wr_burst_addr are held stable.
  - A words_sent counter increments on each accepted pop.
  - Any wr_burst_data_req seen with words_sent==wr_burst_len sets err_overreq and does not pop.
  - On wr_burst_finish: wr_burst_req=0 next cycle, state returns to IDLE, and the address is updated.
- Address update:
  - next = addr + len.
  - If next + BURST_LEN > BASE_ADDR + ADDR_SPAN, next = BASE_ADDR (wrap).
  - Arithmetic is done at ADDR_WIDTH+1 bits to avoid overflow.
- IDLE lasts at least one cycle between bursts.
- A flush pulse during BURST sets flush_pending for evaluation after return to IDLE.
- wr_burst_finish seen in IDLE is ignored.

Test Plan:
- Reset, calib_done=0, push 64 words (0..63) -> no wr_burst_req and fifo_level=64. Raise calib_done -> req rises 1 cycle later, addr=0, len=64. Controller model pops 64 words; wr_burst_data sequence 0..63; finish -> next addr=64.
- Continuous stream with back-to-back bursts and ADDR_SPAN=256 -> addresses 0,64,128,192,0,...; no word lost or duplicated across 1024 words.
- Push 100 words, pulse flush -> full burst len=64 at addr 0, then partial burst len=36 at addr 64; flush_pending=0; fifo_level=0.
- Fill the FIFO to 512 with calib_done=0 -> in_ready=0; the 513th in_valid word is not accepted; data integrity is kept after draining.
- Controller model issues 65 data_req for a len=64 burst -> err_overreq=1 (sticky), fifo_level drops by exactly 64.
- Assert rst_n low mid-burst after 10 pops -> all outputs return to reset values asynchronously; after release the FIFO is empty and addr=BASE_ADDR.
